// File: rtl/uart_rng_peripheral.sv
// 8N1 UART transmitter/receiver with byte handshakes plus a free-running 16-bit LFSR bit source.
// Define UART_LOOPBACK_EN to feed the receiver from the internal TX line instead of uart_rxd.
module uart_rng_peripheral #(
  parameter int CLOCK_RATE = 25000000,
  parameter int BAUD_RATE  = 115200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tx_en,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       uart_txd,
  input  logic       rx_en,
  input  logic       uart_rxd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       rx_err,
  output logic       random_bit
);

  localparam int DIV = CLOCK_RATE / BAUD_RATE;
  localparam int CW  = $clog2(DIV + 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(DIV / 2 - 1);

  // ---------------- transmitter ----------------
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

  tx_state_t       tx_state_q;
  logic [CW-1:0]   tx_cnt_q;
  logic [2:0]      tx_bit_q;
  logic [7:0]      tx_shift_q;
  logic            txd_q;

  assign tx_ready = (tx_state_q == TX_IDLE) && tx_en;
  assign uart_txd = txd_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      txd_q      <= 1'b1;
    end else begin
      unique case (tx_state_q)
        TX_IDLE: begin
          txd_q <= 1'b1;
          if (tx_valid && tx_ready) begin
            tx_shift_q <= tx_data;
            txd_q      <= 1'b0;
            tx_cnt_q   <= '0;
            tx_state_q <= TX_START;
          end
        end
        TX_START: begin
          if (tx_cnt_q == BIT_LAST) begin
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            txd_q      <= tx_shift_q[0];
            tx_shift_q <= {1'b0, tx_shift_q[7:1]};
            tx_state_q <= TX_DATA;
          end else begin
            tx_cnt_q <= tx_cnt_q + 1'b1;
          end
        end
        TX_DATA: begin
          if (tx_cnt_q == BIT_LAST) begin
            tx_cnt_q <= '0;
            if (tx_bit_q == 3'd7) begin
              txd_q      <= 1'b1;
              tx_state_q <= TX_STOP;
            end else begin
              txd_q      <= tx_shift_q[0];
              tx_shift_q <= {1'b0, tx_shift_q[7:1]};
              tx_bit_q   <= tx_bit_q + 1'b1;
            end
          end else begin
            tx_cnt_q <= tx_cnt_q + 1'b1;
          end
        end
        TX_STOP: begin
          if (tx_cnt_q == BIT_LAST) begin
            tx_cnt_q   <= '0;
            tx_state_q <= TX_IDLE;
          end else begin
            tx_cnt_q <= tx_cnt_q + 1'b1;
          end
        end
        default: tx_state_q <= TX_IDLE;
      endcase
    end
  end

  // ---------------- receiver ----------------
  logic rx_src;
`ifdef UART_LOOPBACK_EN
  assign rx_src = txd_q;
`else
  assign rx_src = uart_rxd;
`endif

  logic rx_meta_q, rx_sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= rx_src;
      rx_sync_q <= rx_meta_q;
    end
  end

  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BREAK} rx_state_t;

  rx_state_t     rx_state_q;
  logic [CW-1:0] rx_cnt_q;
  logic [2:0]    rx_bit_q;
  logic [7:0]    rx_shift_q;
  logic [7:0]    rx_data_q;
  logic          rx_valid_q;
  logic          rx_err_q;

  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign rx_err   = rx_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_err_q   <= 1'b0;
    end else begin
      rx_err_q <= 1'b0;
      if (rx_valid_q && rx_ready) begin
        rx_valid_q <= 1'b0;
      end
      unique case (rx_state_q)
        RX_IDLE: begin
          if (rx_en && !rx_sync_q) begin
            rx_cnt_q   <= '0;
            rx_state_q <= RX_START;
          end
        end
        RX_START: begin
          if (rx_cnt_q == HALF_LAST) begin
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_state_q <= rx_sync_q ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt_q <= rx_cnt_q + 1'b1;
          end
        end
        RX_DATA: begin
          if (rx_cnt_q == BIT_LAST) begin
            rx_cnt_q   <= '0;
            rx_shift_q <= {rx_sync_q, rx_shift_q[7:1]};
            rx_bit_q   <= rx_bit_q + 1'b1;
            if (rx_bit_q == 3'd7) begin
              rx_state_q <= RX_STOP;
            end
          end else begin
            rx_cnt_q <= rx_cnt_q + 1'b1;
          end
        end
        RX_STOP: begin
          if (rx_cnt_q == BIT_LAST) begin
            rx_cnt_q <= '0;
            if (rx_sync_q) begin
              // Overrun keeps the unconsumed byte and flags the loss instead.
              if (rx_valid_q) begin
                rx_err_q <= 1'b1;
              end else begin
                rx_data_q  <= rx_shift_q;
                rx_valid_q <= 1'b1;
              end
              rx_state_q <= RX_IDLE;
            end else begin
              rx_err_q   <= 1'b1;
              rx_state_q <= RX_BREAK;
            end
          end else begin
            rx_cnt_q <= rx_cnt_q + 1'b1;
          end
        end
        RX_BREAK: begin
          if (rx_sync_q) begin
            rx_state_q <= RX_IDLE;
          end
        end
        default: rx_state_q <= RX_IDLE;
      endcase
    end
  end

  // ---------------- LFSR ----------------
  logic [15:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= 16'hACE1;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign random_bit = lfsr_q[0];

endmodule

// File: tb/tb_uart_rng_peripheral.sv
// Directed self-checking bench for uart_rng_peripheral (default build and UART_LOOPBACK_EN build).
module tb_uart_rng_peripheral;

  localparam int DIV = 217;

  logic       clk;
  logic       rst_n;
  logic       tx_en;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic       uart_txd;
  logic       rx_en;
  logic       uart_rxd;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       rx_err;
  logic       random_bit;

  uart_rng_peripheral #(
    .CLOCK_RATE(25000000),
    .BAUD_RATE (115200)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .tx_en     (tx_en),
    .tx_valid  (tx_valid),
    .tx_data   (tx_data),
    .tx_ready  (tx_ready),
    .uart_txd  (uart_txd),
    .rx_en     (rx_en),
    .uart_rxd  (uart_rxd),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .rx_err    (rx_err),
    .random_bit(random_bit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  int err_cycles;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic send_rx(input logic [7:0] d, input logic stop_bit);
    logic [9:0] frame;
    frame = {stop_bit, d, 1'b0};
    err_cycles = 0;
    for (int b = 0; b < 10; b++) begin
      uart_rxd = frame[b];
      repeat (DIV) begin
        @(negedge clk);
        if (rx_err === 1'b1) err_cycles++;
      end
    end
    uart_rxd = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (rx_err === 1'b1) err_cycles++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] model;
    logic [9:0]  tx_frame;
    logic [9:0]  bad;
    logic [9:0]  mid;
    int          i;
    int          lat;

    rst_n    = 1'b0;
    tx_en    = 1'b1;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    rx_en    = 1'b1;
    uart_rxd = 1'b1;
`ifdef UART_LOOPBACK_EN
    rx_ready = 1'b1;
`else
    rx_ready = 1'b0;
`endif
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    check("reset txd", uart_txd, 1);
    check("reset tx_ready", tx_ready, 1);
    check("reset rx_valid", rx_valid, 0);
    check("reset rx_err", rx_err, 0);
    check("reset rx_data", rx_data, 0);

    model = 16'hACE1;
    for (int k = 0; k < 16; k++) begin
      check($sformatf("lfsr bit %0d", k), random_bit, model[0]);
      @(posedge clk);
      model = {model[14:0], model[15] ^ model[13] ^ model[12] ^ model[10]};
      @(negedge clk);
    end

    // TX 0x55: one tx_valid cycle, then check every cycle of the frame
    tx_data  = 8'h55;
    tx_valid = 1'b1;
    check("tx ready before send", tx_ready, 1);
    @(negedge clk);
    tx_valid = 1'b0;
    check("tx start txd", uart_txd, 0);
    check("tx busy ready", tx_ready, 0);
    tx_frame = {1'b1, 8'h55, 1'b0};
    bad = '0;
    mid = '1;
    i = 0;
    while (tx_ready === 1'b0 && i < 3000) begin
      if (i / DIV < 10) begin
        if (uart_txd !== tx_frame[i / DIV]) bad[i / DIV] = 1'b1;
        if (i % DIV == DIV / 2) mid[i / DIV] = uart_txd;
      end
      i++;
      @(negedge clk);
    end
    check("tx frame mid samples", {6'd0, mid}, {6'd0, 10'b1010101010});
    check("tx frame bits stable", {6'd0, bad}, 16'd0);
    check("tx ready low cycles", i[15:0], 16'd2170);
    check("tx idle after frame", uart_txd, 1);
    check("tx ready after frame", tx_ready, 1);

    // tx_en low: no frame accepted
    tx_en    = 1'b0;
    tx_valid = 1'b1;
    tx_data  = 8'hFF;
    @(negedge clk);
    check("tx_en low ready", tx_ready, 0);
    repeat (20) @(negedge clk);
    check("tx_en low txd idle", uart_txd, 1);
    tx_valid = 1'b0;
    tx_en    = 1'b1;
    @(negedge clk);
    check("tx_en high ready", tx_ready, 1);

`ifdef UART_LOOPBACK_EN
    repeat (10) @(negedge clk);
    tx_data  = 8'h4F;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    lat = 0;
    while (rx_valid !== 1'b1 && lat < 3000) begin
      @(negedge clk);
      lat++;
    end
    check("loopback rx_valid", rx_valid, 1);
    check("loopback rx_data", rx_data, 16'h004F);
    check("loopback latency window", {15'd0, (lat >= 2000 && lat <= 2300)}, 1);
`else
    check("rx idle valid", rx_valid, 0);
    send_rx(8'hA3, 1'b1);
    check("rx A3 valid", rx_valid, 1);
    check("rx A3 data", rx_data, 16'h00A3);
    check("rx A3 no err", err_cycles[15:0], 0);
    repeat (10) @(negedge clk);
    check("rx A3 valid held", rx_valid, 1);
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    check("rx A3 valid cleared", rx_valid, 0);
    check("rx A3 data kept", rx_data, 16'h00A3);

    send_rx(8'h5A, 1'b0);
    check("rx framing err pulse", err_cycles[15:0], 1);
    check("rx framing no valid", rx_valid, 0);

    send_rx(8'h31, 1'b1);
    check("rx 31 valid", rx_valid, 1);
    check("rx 31 data", rx_data, 16'h0031);
    check("rx 31 no err", err_cycles[15:0], 0);
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;

    send_rx(8'h30, 1'b1);
    check("rx 30 data", rx_data, 16'h0030);
    send_rx(8'h20, 1'b1);
    check("overrun err pulse", err_cycles[15:0], 1);
    check("overrun data kept", rx_data, 16'h0030);
    check("overrun valid kept", rx_valid, 1);
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    check("overrun cleared", rx_valid, 0);

    rx_en = 1'b0;
    send_rx(8'h77, 1'b1);
    check("rx_en low no valid", rx_valid, 0);
    check("rx_en low no err", err_cycles[15:0], 0);
    rx_en = 1'b1;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
